// File: rtl/booth_array_16bit_optimized.sv
// Signed 16x16 radix-4 Booth multiplier, 1- or 2-stage latency
// selectable per cycle, with operand isolation on zero inputs.
module booth_array_16bit_optimized (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        pipeline_en,
  output logic [31:0] prod,
  output logic        power_saved
);

  logic        zero;
  logic [15:0] hold_a;
  logic [15:0] hold_b;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [31:0] ax;
  logic [16:0] bx;
  logic [31:0] pp [8];
  logic [31:0] sum_lo;
  logic [31:0] sum_hi;
  logic [31:0] full;
  logic [31:0] s1_lo;
  logic [31:0] s1_hi;
  logic        s1_zero;
  logic [31:0] s1_full;

  assign zero = (a == 16'd0) | (b == 16'd0);

  // A zero operand freezes the array inputs at the last non-zero pair
  assign op_a = zero ? hold_a : a;
  assign op_b = zero ? hold_b : b;

  assign ax = {{16{op_a[15]}}, op_a};
  assign bx = {op_b, 1'b0};

  for (genvar g = 0; g < 8; g++) begin : g_pp
    logic [2:0]  grp;
    logic        one;
    logic        two;
    logic        neg;
    logic [31:0] mag;
    logic [31:0] sgn;

    assign grp = bx[2*g +: 3];
    assign one = grp[1] ^ grp[0];
    assign two = (grp == 3'b011) | (grp == 3'b100);
    assign neg = grp[2] & ~(grp[1] & grp[0]);
    assign mag = two ? {ax[30:0], 1'b0} : (one ? ax : 32'd0);
    assign sgn = neg ? (~mag + 32'd1) : mag;
    assign pp[g] = sgn << (2 * g);
  end

  assign sum_lo  = pp[0] + pp[1] + pp[2] + pp[3];
  assign sum_hi  = pp[4] + pp[5] + pp[6] + pp[7];
  assign full    = sum_lo + sum_hi;
  assign s1_full = s1_lo + s1_hi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_a      <= '0;
      hold_b      <= '0;
      s1_lo       <= '0;
      s1_hi       <= '0;
      s1_zero     <= 1'b0;
      prod        <= '0;
      power_saved <= 1'b0;
    end else if (enable) begin
      if (!zero) begin
        hold_a <= a;
        hold_b <= b;
      end
      s1_lo   <= sum_lo;
      s1_hi   <= sum_hi;
      s1_zero <= zero;
      if (pipeline_en) begin
        prod        <= s1_zero ? 32'd0 : s1_full;
        power_saved <= s1_zero;
      end else begin
        prod        <= zero ? 32'd0 : full;
        power_saved <= zero;
      end
    end
  end

endmodule

// File: tb/tb_booth_array_16bit_optimized.sv
// Directed and model-checked stimulus for the Booth multiplier.
// Inputs change 1 time unit after each rising edge.
module tb_booth_array_16bit_optimized;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] a;
  logic [15:0] b;
  logic        pipeline_en;
  logic [31:0] prod;
  logic        power_saved;

  int n_chk;
  int n_pass;

  booth_array_16bit_optimized dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .a           (a),
    .b           (b),
    .pipeline_en (pipeline_en),
    .prod        (prod),
    .power_saved (power_saved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic [15:0] va, input logic [15:0] vb,
                      input logic pe, input logic en);
    a = va;
    b = vb;
    pipeline_en = pe;
    enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string tag, input logic [31:0] ep,
                      input logic es);
    chk({tag, ".prod"}, prod, ep);
    chk({tag, ".ps"}, {31'd0, power_saved}, {31'd0, es});
  endtask

  logic signed [15:0] ra;
  logic signed [15:0] rb;
  logic signed [31:0] m_p;
  logic [31:0] m_s1;
  logic        m_s1z;
  logic [31:0] m_prod;
  logic        m_ps;
  logic        rz;
  logic        ren;
  logic        rpe;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    pipeline_en = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk2("reset", 32'd0, 1'b0);

    rst_n = 1'b1;
    step(16'd1234, 16'd5678, 1'b0, 1'b1);
    chk2("basic", 32'd7006652, 1'b0);
    step(16'd0, 16'd5678, 1'b0, 1'b1);
    chk2("zero_a", 32'd0, 1'b1);
    step(16'd1234, 16'd0, 1'b0, 1'b1);
    chk2("zero_b", 32'd0, 1'b1);
    step(16'd1, 16'd1, 1'b0, 1'b1);
    chk2("one", 32'd1, 1'b0);

    step(-16'sd3333, 16'd4444, 1'b0, 1'b1);
    chk2("neg_pos", -32'sd14811852, 1'b0);
    step(-16'sd2222, -16'sd3333, 1'b0, 1'b1);
    chk2("neg_neg", 32'd7405926, 1'b0);
    step(16'h7fff, 16'h7fff, 1'b0, 1'b1);
    chk2("max_max", 32'h3fff0001, 1'b0);
    step(16'h8000, 16'h8000, 1'b0, 1'b1);
    chk2("min_min", 32'h40000000, 1'b0);
    step(16'h8000, 16'h7fff, 1'b0, 1'b1);
    chk2("min_max", 32'hc0008000, 1'b0);

    // 0->1: first pipelined output is the pair from one cycle earlier
    step(16'd1111, 16'd2222, 1'b1, 1'b1);
    chk2("sw01", 32'hc0008000, 1'b0);
    step(16'd3333, 16'd4444, 1'b1, 1'b1);
    chk2("pipe0", 32'd2468642, 1'b0);
    step(16'd5555, 16'd6666, 1'b1, 1'b1);
    chk2("pipe1", 32'd14811852, 1'b0);
    step(16'd7, 16'd8, 1'b1, 1'b1);
    chk2("pipe2", 32'd37029630, 1'b0);

    // 1->0: the 7x8 product in stage 1 is dropped
    step(16'd0, 16'd9999, 1'b0, 1'b1);
    chk2("sw10", 32'd0, 1'b1);

    step(16'd100, 16'd200, 1'b1, 1'b0);
    chk2("hold0", 32'd0, 1'b1);
    step(16'd300, 16'd400, 1'b0, 1'b0);
    chk2("hold1", 32'd0, 1'b1);
    step(16'd500, 16'd600, 1'b1, 1'b0);
    chk2("hold2", 32'd0, 1'b1);
    step(16'd2, 16'd3, 1'b1, 1'b1);
    chk2("hold_s1", 32'd0, 1'b1);
    step(16'd4, 16'd5, 1'b1, 1'b1);
    chk2("resume", 32'd6, 1'b0);
    step(16'd9, 16'd9, 1'b1, 1'b1);
    chk2("pre_rst", 32'd20, 1'b0);

    rst_n = 1'b0;
    step(16'd11, 16'd11, 1'b1, 1'b1);
    chk2("mid_rst", 32'd0, 1'b0);
    rst_n = 1'b1;
    step(16'd3, 16'd3, 1'b1, 1'b1);
    chk2("post_rst0", 32'd0, 1'b0);
    step(16'd1, 16'd2, 1'b1, 1'b1);
    chk2("post_rst1", 32'd9, 1'b0);

    // Random section against a latency-aware model
    m_s1  = 32'd2;
    m_s1z = 1'b0;
    m_prod = prod;
    m_ps   = power_saved;
    for (int i = 0; i < 4000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ra = '0;
      if ($urandom_range(0, 15) == 0) rb = '0;
      ren = ($urandom_range(0, 7) != 0);
      rpe = (i < 2000) ? ($urandom_range(0, 7) != 0)
                       : ($urandom_range(0, 7) == 0);
      step(ra, rb, rpe, ren);
      m_p = ra * rb;
      rz  = (ra == 16'sd0) || (rb == 16'sd0);
      if (ren) begin
        if (rpe) begin
          m_prod = m_s1z ? 32'd0 : m_s1;
          m_ps   = m_s1z;
        end else begin
          m_prod = rz ? 32'd0 : m_p;
          m_ps   = rz;
        end
        m_s1  = m_p;
        m_s1z = rz;
      end
      chk2("rand", m_prod, m_ps);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
